// File: rtl/shift_unit_seq_if.sv
// Request/response bundle for the sequential shift unit.
// The master drives the request and the result-ready. The slave (the unit) drives the
// handshake status and the result.
interface shift_unit_seq_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             shamt_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output in_valid,
        output op,
        output a,
        output b,
        output shamt,
        output shamt_sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  op,
        input  a,
        input  b,
        input  shamt,
        input  shamt_sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output busy
    );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle barrel-less shifter: SLL / SRL / SRA / ROL by up to WIDTH-1 bit positions.
// Each SHIFT cycle moves the operand by at most STEP bits.
// A request is accepted in IDLE. The unit walks the remaining distance in SHIFT and
// presents the result in DONE until the consumer takes it.
// All handshake outputs and the result come straight from flops.
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic           clk,
    input  logic           rst,
    shift_unit_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    // STEP may equal WIDTH, so the per-cycle distance needs one extra bit.
    localparam logic [SHW:0]   STEP_W  = (SHW+1)'(STEP);
    localparam logic [SHW+1:0] WIDTH_W = (SHW+2)'(WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   rem_q;
    logic [WIDTH-1:0] out_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [SHW-1:0]   sel_amt;
    logic [SHW:0]     step_amt;
    logic [SHW+1:0]   rot_back;
    logic [WIDTH-1:0] work_d;
    logic [SHW-1:0]   rem_d;

    // Pick the shift amount source; the register form uses only the low SHW bits of b.
    always_comb begin
        sel_amt = bus.shamt;
        if (bus.shamt_sel) begin
            sel_amt = bus.b[SHW-1:0];
        end else begin
            sel_amt = bus.shamt;
        end
    end

    // One SHIFT cycle: move the working value by min(remaining, STEP).
    always_comb begin
        step_amt = STEP_W;
        if ({1'b0, rem_q} < STEP_W) begin
            step_amt = {1'b0, rem_q};
        end else begin
            step_amt = STEP_W;
        end

        // Complementary distance for the wrapped-around part of a rotate.
        // A distance of zero gives WIDTH here, and a right shift by WIDTH yields zero.
        rot_back = WIDTH_W - {1'b0, step_amt};

        case (op_q)
            OP_SLL:  work_d = work_q << step_amt;
            OP_SRL:  work_d = work_q >> step_amt;
            OP_SRA:  work_d = $signed(work_q) >>> step_amt;
            OP_ROL:  work_d = (work_q << step_amt) | (work_q >> rot_back);
            default: work_d = work_q;
        endcase

        // step_amt never exceeds rem_q, so the truncation to SHW bits is lossless.
        rem_d = rem_q - step_amt[SHW-1:0];
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_SLL;
            work_q      <= '0;
            rem_q       <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= bus.op;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (sel_amt == '0) begin
                            // Zero distance: the operand is already the answer.
                            out_q       <= bus.a;
                            rem_q       <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            work_q      <= bus.a;
                            rem_q       <= sel_amt;
                            out_valid_q <= 1'b0;
                            state_q     <= S_SHIFT;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        out_q       <= work_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_SHIFT;
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a clean idle without a result.
                    state_q     <= S_IDLE;
                    rem_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq (WIDTH=32, STEP=4).
// Stimulus pushes the expected result and its arrival cycle into a queue. A monitor
// pops and compares the queue entry when out_valid rises, and it also checks hold
// behaviour in DONE.
module tb_shift_unit_seq;
    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;
    exp_t sb_q[$];
    int   hold_req;

    shift_unit_seq_if #(.WIDTH(WIDTH)) bus ();

    shift_unit_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Reference: plain whole-word shift by the full amount.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt);
        logic [63:0] dbl;
        case (op)
            2'b00:   return a << amt;
            2'b01:   return a >> amt;
            2'b10:   return 32'($signed(a) >>> amt);
            default: begin
                dbl = {a, a} << amt;
                return dbl[63:32];
            end
        endcase
    endfunction

    // While the unit is busy, present live-looking requests that must be ignored.
    task automatic drive_junk();
        bus.in_valid  = ~bus.in_ready;
        bus.op        = 2'($urandom_range(0, 3));
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.shamt     = 5'($urandom_range(0, 31));
        bus.shamt_sel = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic sel, input bit use_exp,
                         input logic [31:0] exp_val, input int hold);
        int   waited;
        bit   ok;
        logic [4:0] amt;
        exp_t e;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited <= 200) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else begin
                drive_junk();
                waited++;
            end
        end
        if (!ok) begin
            fail_now("issue_timeout");
            return;
        end
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.shamt     = sh;
        bus.shamt_sel = sel;
        amt   = sel ? b[4:0] : sh;
        e.val = use_exp ? exp_val : model(op, a, amt);
        e.cyc = cyc + 1 + (int'(amt) + STEP - 1) / STEP;
        sb_q.push_back(e);
        hold_req = hold;
        @(posedge clk);
        #1;
        // Scramble every input right after acceptance; the in-flight result must not care.
        bus.in_valid  = 1'b0;
        bus.op        = 2'($urandom_range(0, 3));
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.shamt     = 5'($urandom_range(0, 31));
        bus.shamt_sel = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.in_ready && sb_q.size() == 0) begin
                bus.in_valid = 1'b0;
                return;
            end
            if (!bus.in_ready) drive_junk();
            else bus.in_valid = 1'b0;
        end
        fail_now("drain_timeout");
    endtask

    // Monitor: compare results on out_valid rise, then police the DONE hold and release.
    logic        prev_valid;
    logic        last_ready;
    logic [31:0] held_out;
    int          hold_cnt;
    exp_t        got_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            last_ready = 1'b1;
            held_out   = 32'h0;
            hold_cnt   = 0;
        end else begin
            check("busy_vs_in_ready", {63'd0, bus.busy}, {63'd0, ~bus.in_ready});
            if (prev_valid && !last_ready) check("valid_held", {63'd0, bus.out_valid}, 64'd1);
            if (prev_valid && last_ready)  check("valid_released", {63'd0, bus.out_valid}, 64'd0);
            if (bus.out_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got 0x%0h expected no result (cycle %0d)", bus.out, cyc);
                end else begin
                    got_e = sb_q.pop_front();
                    check("result", {32'd0, bus.out}, {32'd0, got_e.val});
                    check("latency", 64'(cyc), 64'(got_e.cyc));
                end
                held_out = bus.out;
                hold_cnt = hold_req;
            end else if (bus.out_valid) begin
                check("done_out_stable", {32'd0, bus.out}, {32'd0, held_out});
                check("done_in_ready", {63'd0, bus.in_ready}, 64'd0);
            end else begin
                check("out_kept", {32'd0, bus.out}, {32'd0, held_out});
            end
            if (bus.out_valid) begin
                if (hold_cnt > 0) begin
                    bus.out_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end else begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            last_ready = bus.out_ready;
            prev_valid = bus.out_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        n_pass = 0;
        n_total = 0;
        hold_req = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = 2'b00;
        bus.a = 32'h0;
        bus.b = 32'h0;
        bus.shamt = 5'd0;
        bus.shamt_sel = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_out", {32'd0, bus.out}, 64'd0);
        rst = 1'b0;

        // Directed corner cases with hand-computed expectations.
        issue(2'b00, 32'h0000_0001, 32'h0, 5'd31, 1'b0, 1'b1, 32'h8000_0000, 0);
        issue(2'b10, 32'h8000_0000, 32'h0, 5'd4,  1'b0, 1'b1, 32'hF800_0000, 0);
        issue(2'b01, 32'h8000_0000, 32'h0, 5'd4,  1'b0, 1'b1, 32'h0800_0000, 1);
        issue(2'b10, 32'h1234_5678, 32'h0, 5'd0,  1'b0, 1'b1, 32'h1234_5678, 0);
        issue(2'b11, 32'h8000_0001, 32'h0000_0021, 5'd17, 1'b1, 1'b1, 32'h0000_0003, 0);
        // Consumer stalls for 5 cycles while junk requests keep arriving.
        issue(2'b00, 32'h0000_00F0, 32'h0, 5'd8,  1'b0, 1'b1, 32'h0000_F000, 5);
        issue(2'b11, 32'hDEAD_BEEF, 32'h0, 5'd0,  1'b0, 1'b1, 32'hDEAD_BEEF, 5);
        drain();

        // Reset in the middle of a 20-bit SLL discards it.
        issue(2'b00, 32'hFFFF_FFFF, 32'h0, 5'd20, 1'b0, 1'b1, 32'hFFF0_0000, 0);
        @(negedge clk);
        drive_junk();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        sb_q.delete();
        check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_out", {32'd0, bus.out}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_late", {63'd0, bus.out_valid}, 64'd0);
        end

        // Randomized traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            issue(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'b0, 32'h0, $urandom_range(0, 2));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 Parameter WIDTH, default 32, meaning operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter STEP, default 4, meaning maximum shift distance applied per SHIFT cycle; SHALL be a power of two, 1..WIDTH.
REQ-003 Derived constant SHW = log2(WIDTH), meaning shift-amount width; SHALL NOT be a user parameter.
REQ-004 Clock: one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port in_valid, input, 1, request present.
REQ-008 Port in_ready, output, 1, unit can accept a request.
REQ-009 Port op, input, 2, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 Port a, input, WIDTH, signed operand to shift.
REQ-011 Port b, input, WIDTH, register-sourced amount; only b[SHW-1:0] is used.
REQ-012 Port shamt, input, SHW, immediate shift amount.
REQ-013 Port shamt_sel, input, 1, 0 = amount from shamt, 1 = amount from b[SHW-1:0].
REQ-014 Port out_valid, output, 1, result available.
REQ-015 Port out_ready, input, 1, consumer takes result.
REQ-016 Port out, output, WIDTH, signed result register.
REQ-017 Port busy, output, 1, high in SHIFT or DONE.

Function
REQ-018 FSM states IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 Acceptance: in IDLE with in_valid=1, the edge latches op, a, and amt (selected per shamt_sel) into internal registers.
REQ-020 On acceptance, amt=0 -> DONE with out=a; amt>0 -> SHIFT with working value=a, remaining=amt.
REQ-021 Each SHIFT edge applies d=min(remaining, STEP) to the working value and decrements remaining by d; on the edge where remaining reaches 0, the final value is loaded into out and the state goes to DONE.
REQ-022 Latency: out_valid SHALL rise ceil(amt/STEP) edges after the accepting edge (next cycle when amt=0).
REQ-023 SLL fills with zeros; SRL fills with zeros; SRA fills with a[WIDTH-1]; ROL rotates left, bit WIDTH-1 wrapping to bit 0.
REQ-024 The result SHALL equal a single-cycle shift of a by amt for all amt in 0..WIDTH-1; amount is always taken modulo WIDTH via SHW-bit truncation.
REQ-025 DONE with out_ready=1 -> IDLE next edge; out_ready=0 -> remain in DONE, out stable.
REQ-026 in_valid outside IDLE SHALL be ignored; a request presented in the same cycle as the out_ready handshake is accepted no earlier than the following IDLE cycle.
REQ-027 out SHALL hold its last value in IDLE and SHIFT until overwritten at the next completion or zero-amount acceptance.
REQ-028 Changes on a, b, shamt, op, or shamt_sel after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-029 rst=1 at an edge -> state IDLE, out=0, out_valid=0, busy=0, in_ready=1, internal remaining=0; takes priority over all other inputs.
REQ-030 Reset mid-SHIFT or in DONE SHALL discard the in-flight operation with no out_valid pulse.

Verification (WIDTH=32, STEP=4)
REQ-031 SLL, a=0x00000001, shamt=31, shamt_sel=0 -> out=0x80000000, out_valid 8 edges after acceptance.
REQ-032 SRA, a=0x80000000, shamt=4 -> out=0xF8000000 after 1 edge; SRL with the same operands -> 0x08000000.
REQ-033 SRA, a=0x12345678, shamt=0 -> out=0x12345678, out_valid in the cycle right after acceptance.
REQ-034 ROL, a=0x80000001, shamt_sel=1, b=0x00000021 (amount 1) -> out=0x00000003.
REQ-035 out_ready held 0 for 5 cycles in DONE, with in_valid=1 and a new a -> out and out_valid held, in_ready=0, new request accepted only after the handshake.
REQ-036 rst pulsed during SHIFT of an amt=20 SLL -> next cycle in_ready=1, out_valid=0, out=0, and no late result appears.
